// File: rtl/dummy_adc_if.sv
// ============================================================================
// dummy_adc_if : byte-wide capture FIFO write port of the dummy stereo ADC
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface dummy_adc_if;
    logic       fifo_clk;
    logic [7:0] fifo_data;
    logic       fifo_write;
    logic       fifo_full;

    modport master (
        output fifo_clk,
        output fifo_data,
        output fifo_write,
        input  fifo_full
    );

    modport slave (
        input  fifo_clk,
        input  fifo_data,
        input  fifo_write,
        output fifo_full
    );
endinterface

`default_nettype wire

// File: rtl/dummy_adc.sv
// ============================================================================
// dummy_adc : deserializes a 16-bit stereo DATA/LRCK/BCK stream and writes
//             each frame as 4 bytes into the slot capture FIFO
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dummy_adc #(
    parameter int SYNC_STAGES = 2,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   direction,
    input  logic [5:0]             slot_data,
    dummy_adc_if.master            fifo,
    output logic [COUNT_WIDTH-1:0] frame_count,
    output logic [COUNT_WIDTH-1:0] overflow_count
);

    localparam logic [0:0] ST_UNSYNC = 1'b0;
    localparam logic [0:0] ST_SYNCED = 1'b1;

    localparam logic [2:0] WR_IDLE = 3'd0;
    localparam logic [2:0] WR_W0   = 3'd1;
    localparam logic [2:0] WR_W1   = 3'd2;
    localparam logic [2:0] WR_W2   = 3'd3;
    localparam logic [2:0] WR_W3   = 3'd4;

    logic                          active;
    logic [SYNC_STAGES-1:0][2:0]   sync_q;
    logic                          data_s, lrck_s, bck_s;
    logic                          bck_prev_q;
    logic                          bck_rise;
    logic                          unused_slot_bits;

    logic                          lrck_prev_q, lrck_prev_d;
    logic [15:0]                   shift_q, shift_d;
    logic [4:0]                    bit_cnt_q, bit_cnt_d;
    logic [15:0]                   closed_word;
    logic [0:0]                    sync_st_q, sync_st_d;
    logic [15:0]                   left_q, left_d;
    logic                          left_valid_q, left_valid_d;
    logic                          frame_ready_q, frame_ready_d;
    logic [31:0]                   frame_q, frame_d;

    logic [2:0]                    wr_st_q, wr_st_d;
    logic [31:0]                   hold_q, hold_d;
    logic [COUNT_WIDTH-1:0]        frame_cnt_q, frame_cnt_d;
    logic [COUNT_WIDTH-1:0]        ovf_cnt_q, ovf_cnt_d;
    logic                          ovf_inc;

    assign active           = enable & direction;
    assign unused_slot_bits = ^slot_data[5:3];
    assign data_s           = sync_q[SYNC_STAGES-1][0];
    assign lrck_s           = sync_q[SYNC_STAGES-1][1];
    assign bck_s            = sync_q[SYNC_STAGES-1][2];
    assign bck_rise         = bck_s & ~bck_prev_q;
    // Left-justify a short word; a 0-bit word shifts out to zero.
    assign closed_word      = shift_q << (5'd16 - bit_cnt_q);

    always_comb begin
        lrck_prev_d   = lrck_prev_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        sync_st_d     = sync_st_q;
        left_d        = left_q;
        left_valid_d  = left_valid_q;
        frame_ready_d = 1'b0;
        frame_d       = frame_q;
        if (bck_rise) begin
            lrck_prev_d = lrck_s;
            if (lrck_s == lrck_prev_q) begin
                if (bit_cnt_q < 5'd16) begin
                    shift_d   = {shift_q[14:0], data_s};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                end
            end else begin
                shift_d   = {15'd0, data_s};
                bit_cnt_d = 5'd1;
                case (sync_st_q)
                    ST_UNSYNC: begin
                        if (lrck_prev_q) begin
                            sync_st_d    = ST_SYNCED;
                            left_valid_d = 1'b0;
                        end
                    end
                    default: begin
                        if (!lrck_prev_q) begin
                            left_d       = closed_word;
                            left_valid_d = 1'b1;
                        end else begin
                            if (left_valid_q) begin
                                frame_ready_d = 1'b1;
                                frame_d       = {closed_word, left_q};
                            end
                            left_valid_d = 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    always_comb begin
        wr_st_d     = wr_st_q;
        hold_d      = hold_q;
        frame_cnt_d = frame_cnt_q;
        ovf_cnt_d   = ovf_cnt_q;
        ovf_inc     = 1'b0;
        case (wr_st_q)
            WR_IDLE: begin
                if (frame_ready_q) begin
                    if (fifo.fifo_full) begin
                        ovf_inc = 1'b1;
                    end else begin
                        hold_d  = frame_q;
                        wr_st_d = WR_W0;
                    end
                end
            end
            WR_W0: if (!fifo.fifo_full) wr_st_d = WR_W1;
            WR_W1: if (!fifo.fifo_full) wr_st_d = WR_W2;
            WR_W2: if (!fifo.fifo_full) wr_st_d = WR_W3;
            WR_W3: begin
                if (!fifo.fifo_full) begin
                    wr_st_d     = WR_IDLE;
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end
            end
            default: wr_st_d = WR_IDLE;
        endcase
        // A frame arriving while a previous one is still being written is lost.
        if (frame_ready_q && (wr_st_q != WR_IDLE)) ovf_inc = 1'b1;
        if (ovf_inc && (ovf_cnt_q != {COUNT_WIDTH{1'b1}})) ovf_cnt_d = ovf_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset || !active) begin
            sync_q        <= '0;
            bck_prev_q    <= 1'b0;
            lrck_prev_q   <= 1'b0;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            sync_st_q     <= ST_UNSYNC;
            left_q        <= '0;
            left_valid_q  <= 1'b0;
            frame_ready_q <= 1'b0;
            frame_q       <= '0;
            wr_st_q       <= WR_IDLE;
            hold_q        <= '0;
            if (reset) begin
                frame_cnt_q <= '0;
                ovf_cnt_q   <= '0;
            end
        end else begin
            sync_q[0] <= slot_data[2:0];
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            bck_prev_q    <= bck_s;
            lrck_prev_q   <= lrck_prev_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            sync_st_q     <= sync_st_d;
            left_q        <= left_d;
            left_valid_q  <= left_valid_d;
            frame_ready_q <= frame_ready_d;
            frame_q       <= frame_d;
            wr_st_q       <= wr_st_d;
            hold_q        <= hold_d;
            frame_cnt_q   <= frame_cnt_d;
            ovf_cnt_q     <= ovf_cnt_d;
        end
    end

    always_comb begin
        case (wr_st_q)
            WR_W0:   fifo.fifo_data = hold_q[7:0];
            WR_W1:   fifo.fifo_data = hold_q[15:8];
            WR_W2:   fifo.fifo_data = hold_q[23:16];
            WR_W3:   fifo.fifo_data = hold_q[31:24];
            default: fifo.fifo_data = 8'h00;
        endcase
    end

    assign fifo.fifo_clk   = clk;
    assign fifo.fifo_write = active & (wr_st_q != WR_IDLE) & ~fifo.fifo_full;
    assign frame_count     = frame_cnt_q;
    assign overflow_count  = ovf_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_dummy_adc.sv
// ============================================================================
// tb_dummy_adc : directed stereo streams against a byte-queue model of the
//                expected FIFO writes and frame/overflow counters
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dummy_adc;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        direction;
    logic [5:0]  slot_data;
    logic        fifo_full;
    logic [15:0] frame_count;
    logic [15:0] overflow_count;

    dummy_adc_if fif();
    assign fif.fifo_full = fifo_full;

    dummy_adc #(.SYNC_STAGES(2), .COUNT_WIDTH(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .direction      (direction),
        .slot_data      (slot_data),
        .fifo           (fif),
        .frame_count    (frame_count),
        .overflow_count (overflow_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    int          pos    = 0;
    int          exp_frames   = 0;
    int          exp_overflow = 0;
    bit          force_full_next = 1'b0;
    logic [7:0]  expq[$];
    logic [7:0]  wlog[$];
    int          wcyc[$];
    logic [7:0]  b;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    // Model: each accepted frame is four bytes popped in order, one per
    // unstalled cycle; the fourth byte completes a frame.
    always @(negedge clk) begin
        if (!reset) begin
            if (fif.fifo_write) begin
                n_cmp++;
                if (fifo_full) begin
                    n_fail++;
                    $display("FAIL strobe_while_full: fifo_write=1 required 0");
                end else if (expq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write: data=%h, no write required", fif.fifo_data);
                end else begin
                    b = expq.pop_front();
                    wlog.push_back(fif.fifo_data);
                    wcyc.push_back(cyc);
                    if (fif.fifo_data !== b) begin
                        n_fail++;
                        $display("FAIL byte: got %h required %h", fif.fifo_data, b);
                    end
                    pos = (pos + 1) % 4;
                    if (pos == 0) exp_frames++;
                end
            end else if (pos != 0) begin
                n_cmp++;
                if (!fifo_full) begin
                    n_fail++;
                    $display("FAIL gap: fifo_write=0 mid-frame required 1");
                end else if (fif.fifo_data !== expq[0]) begin
                    n_fail++;
                    $display("FAIL held_data: got %h required %h", fif.fifo_data, expq[0]);
                end
            end
        end
    end

    function automatic logic [15:0] lj(input logic [31:0] v, input int n);
        logic [31:0] t;
        if (n >= 16) t = v >> (n - 16);
        else         t = v << (16 - n);
        return t[15:0];
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input bit lr, input bit d);
        slot_data = {3'b000, 1'b0, lr, d};
        tick(8);
        if (force_full_next) fifo_full = 1'b1;
        slot_data[2] = 1'b1;
        tick(8);
        if (force_full_next) begin
            fifo_full       = 1'b0;
            force_full_next = 1'b0;
        end
    endtask

    task automatic send_word(input bit lr, input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(lr, v[i]);
    endtask

    task automatic send_frame(input logic [31:0] l, input int lb,
                              input logic [31:0] r, input int rb, input bit expect_it);
        logic [15:0] lw, rw;
        lw = lj(l, lb);
        rw = lj(r, rb);
        if (expect_it) begin
            expq.push_back(lw[7:0]);
            expq.push_back(lw[15:8]);
            expq.push_back(rw[7:0]);
            expq.push_back(rw[15:8]);
        end
        send_word(1'b0, l, lb);
        send_word(1'b1, r, rb);
    endtask

    task automatic flush_model();
        expq.delete();
        wlog.delete();
        wcyc.delete();
        pos          = 0;
        exp_frames   = 0;
        exp_overflow = 0;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        slot_data = '0;
        fifo_full = 1'b0;
        tick(3);
        flush_model();
        reset = 1'b0;
        tick(1);
    endtask

    task automatic check_counts(input string nm);
        chk({nm, " frame_count"},    {16'd0, frame_count},    exp_frames);
        chk({nm, " overflow_count"}, {16'd0, overflow_count}, exp_overflow);
    endtask

    task automatic check_bytes(input string nm, input int off, input logic [31:0] req);
        logic [31:0] got;
        got = 32'hxxxx_xxxx;
        if (wlog.size() >= off + 4)
            got = {wlog[off], wlog[off+1], wlog[off+2], wlog[off+3]};
        chk(nm, got, req);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit seen;
        reset     = 1'b1;
        enable    = 1'b1;
        direction = 1'b1;
        slot_data = '0;
        fifo_full = 1'b0;
        tick(1);

        // Model pins
        chk("model lj 18b ones", {16'd0, lj(32'h3FFFF, 18)}, 32'h0000FFFF);
        chk("model lj 12b",      {16'd0, lj(32'h00ABC, 12)}, 32'h0000ABC0);

        // Reset state
        do_reset();
        chk("reset fifo_write", {31'd0, fif.fifo_write}, 32'd0);
        chk("reset fifo_data",  {24'd0, fif.fifo_data},  32'd0);
        check_counts("reset");

        // Normal frame
        send_word(1'b1, 32'h0, 16);
        send_frame(32'h1234, 16, 32'hABCD, 16, 1'b1);
        send_word(1'b0, 32'h0, 1);
        tick(20);
        check_bytes("normal bytes", 0, 32'h3412CDAB);
        chk("normal consecutive", (wcyc.size() >= 4) ? wcyc[3] - wcyc[0] : -1, 32'd3);
        chk("normal frame_count", {16'd0, frame_count}, 32'd1);
        check_counts("normal");

        // Startup mid-right-word
        do_reset();
        send_word(1'b1, 32'h55, 7);
        send_frame(32'h0F0F, 16, 32'hF0F0, 16, 1'b1);
        send_frame(32'h8001, 16, 32'h7FFE, 16, 1'b1);
        send_word(1'b0, 32'h0, 1);
        tick(20);
        check_bytes("startup first frame", 0, 32'h0F0FF0F0);
        check_bytes("startup second frame", 4, 32'h0180FE7F);
        check_counts("startup");

        // Word length
        do_reset();
        send_word(1'b1, 32'h0, 16);
        send_frame(32'h3FFFF, 18, 32'h00001, 18, 1'b1);
        send_frame(32'h00ABC, 12, 32'h00123, 12, 1'b1);
        send_word(1'b0, 32'h0, 1);
        tick(20);
        check_bytes("wordlen 18b", 0, 32'hFFFF0000);
        check_bytes("wordlen 12b", 4, 32'hC0AB3012);
        check_counts("wordlen");

        // FIFO full at frame_ready, then stall in W1
        do_reset();
        send_word(1'b1, 32'h0, 16);
        send_frame(32'hDEAD, 16, 32'hBEEF, 16, 1'b0);
        force_full_next = 1'b1;
        send_frame(32'h1234, 16, 32'hABCD, 16, 1'b1);
        exp_overflow = 1;
        fork
            send_word(1'b0, 32'h0, 1);
            begin
                seen = 1'b0;
                for (int k = 0; k < 400 && !seen; k++) begin
                    @(negedge clk); #1;
                    if (pos == 1) seen = 1'b1;
                end
                if (!seen) begin
                    n_fail++;
                    $display("FAIL stall wait: first byte not written within 400 cycles");
                end else begin
                    @(posedge clk); #1;
                    fifo_full = 1'b1;
                    tick(3);
                    fifo_full = 1'b0;
                end
            end
        join
        tick(20);
        chk("full overflow_count", {16'd0, overflow_count}, 32'd1);
        chk("full frame_count",    {16'd0, frame_count},    32'd1);
        check_bytes("stall bytes", 0, 32'h3412CDAB);

        // Gating via direction
        do_reset();
        send_word(1'b1, 32'h0, 16);
        send_frame(32'h1357, 16, 32'h2468, 16, 1'b1);
        send_word(1'b0, 32'h0, 1);
        tick(20);
        check_counts("gating before");
        direction = 1'b0;
        send_word(1'b0, 32'h0, 15);
        send_word(1'b1, 32'h6666, 16);
        send_frame(32'h7777, 16, 32'h8888, 16, 1'b0);
        send_word(1'b0, 32'h0, 1);
        tick(20);
        chk("gating frame_count held", {16'd0, frame_count}, 32'd1);
        check_counts("gating off");
        direction = 1'b1;
        tick(2);
        send_frame(32'h9999, 16, 32'hAAAA, 16, 1'b0);
        send_frame(32'h0102, 16, 32'h0304, 16, 1'b1);
        send_word(1'b0, 32'h0, 1);
        tick(20);
        chk("gating resumed frame_count", {16'd0, frame_count}, 32'd2);
        check_counts("gating resumed");

        // Reset during W2
        do_reset();
        send_word(1'b1, 32'h0, 16);
        send_frame(32'h1111, 16, 32'h2222, 16, 1'b1);
        send_frame(32'h3333, 16, 32'h4444, 16, 1'b1);
        fork
            send_word(1'b0, 32'h0, 8);
            begin
                seen = 1'b0;
                for (int k = 0; k < 400 && !seen; k++) begin
                    @(negedge clk); #1;
                    if (exp_frames == 1 && pos == 3) seen = 1'b1;
                end
                if (!seen) begin
                    n_fail++;
                    $display("FAIL reset wait: third byte not written within 400 cycles");
                end else begin
                    reset = 1'b1;
                    flush_model();
                    @(negedge clk);
                    chk("reset mid-write fifo_write", {31'd0, fif.fifo_write}, 32'd0);
                    chk("reset mid-write frame_count", {16'd0, frame_count}, 32'd0);
                    chk("reset mid-write overflow_count", {16'd0, overflow_count}, 32'd0);
                    @(posedge clk); #1;
                    reset = 1'b0;
                end
            end
        join
        send_frame(32'h4242, 16, 32'h2424, 16, 1'b0);
        send_word(1'b0, 32'h0, 1);
        tick(20);
        check_counts("after reset unsync");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dummy_adc.md
Name: dummy_adc

Overview:
Capture-side counterpart of the dummy stereo DAC. It accepts a 16-bit stereo serial stream (DATA/LRCK/BCK) on the slot data lines when the slot direction is input. It deserializes left and right words and writes each stereo frame as 4 bytes into the slot's capture FIFO. This exercises the ADC path of the cosim firmware: slot, then FIFO, then FX2.

Parameters:
SYNC_STAGES, 2, flip-flop stages on each slot input before edge detection (minimum 2)
COUNT_WIDTH, 16, width of the frame and overflow counters

Ports:
clk  input  1  system clock (100 MHz); all logic on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  capture enable; low forces idle and resynchronization
direction  input  1  slot direction; 1 = ADC (capture), 0 = inputs ignored
slot_data  input  6  [0]=DATA, [1]=LRCK, [2]=BCK, [5:3] unused
fifo_clk  output  1  FIFO write clock, tied to clk
fifo_data  output  8  byte to write
fifo_write  output  1  write strobe; one byte per cycle while high
fifo_full  input  1  FIFO cannot accept a byte this cycle
frame_count  output  COUNT_WIDTH  frames fully written; wraps modulo 2^COUNT_WIDTH
overflow_count  output  COUNT_WIDTH  frames dropped; saturates at all-ones

Behaviour:
- Reset: fifo_write=0, fifo_data=0, frame_count=0, overflow_count=0. Synchronizers, shift register, bit counter, holding register and FSM are cleared; FSM enters UNSYNC. Reset mid-write abandons the frame with no further strobes.
- active = enable & direction. When active=0: same internal clearing as reset except counters hold; fifo_write=0.
- Inputs pass through SYNC_STAGES flops. bck_rise is a one-cycle pulse when the synchronized BCK goes 0 to 1. DATA and LRCK are sampled on the same cycle.
- At each bck_rise, compare LRCK with lrck_prev (the LRCK value at the previous bck_rise):
  - Unchanged: if bit_cnt<16, shift DATA into the word MSB-first and increment bit_cnt. Bits after the 16th are discarded (bit_cnt saturates at 16).
  - Changed: close the current word. Left-justify it: if fewer than 16 bits arrived, pad the missing LSBs with 0. Store it as left if lrck_prev=0, right if lrck_prev=1. Then restart the word with the current DATA as MSB (bit_cnt=1).
- Sync FSM:
  - UNSYNC: wait for an LRCK 1 to 0 change, discarding the closed word, then go to SYNCED.
  - SYNCED: a left word followed by a right close (LRCK 1 to 0) forms a frame. frame_ready pulses the cycle after the bck_rise that closed the right word.
- Write FSM states: IDLE, W0, W1, W2, W3.
  - In IDLE, on frame_ready: if fifo_full=1, drop the frame and increment overflow_count. Otherwise load the holding register and enter W0 on the next cycle.
  - Wn drives fifo_data = byte n with fifo_write=1. Byte order: left[7:0], left[15:8], right[7:0], right[15:8].
  - If fifo_full=1 during Wn, force fifo_write=0 and hold state and data (stall). Advance when fifo_full=0.
  - W3 accepted: return to IDLE and increment frame_count.
  - Unstalled latency from frame_ready to the first byte is 1 cycle; the 4 bytes occupy 4 consecutive cycles.
- Overrun: if frame_ready occurs while not in IDLE, drop the new frame and increment overflow_count. The in-flight frame is unaffected.
- overflow_count saturates; frame_count wraps.

Test Plan:
- Normal: enable=1, direction=1. Send one sync frame, then left=0x1234, right=0xABCD (BCK period 16 clk). Required: fifo_write high for 4 consecutive cycles with bytes 34, 12, CD, AB; frame_count=1.
- Startup alignment: begin the stream mid-right-word. Required: no writes until after the first LRCK 1 to 0 change; the first written frame is the first complete one.
- Word length: send 18-bit words 0x3FFFF/0x00001, then 12-bit words 0xABC/0x123. Required: 18-bit case writes FF FF 00 00; 12-bit case writes C0 AB 30 12.
- FIFO full: fifo_full=1 at frame_ready. Required: no strobes, overflow_count=1. Then assert fifo_full for 3 cycles during W1. Required: byte 2 held and written after release, with no duplicate or lost bytes.
- Gating: direction=0 with an active stream. Required: fifo_write stays 0 and counters do not change. Return to direction=1: resync before the first write.
- Reset asserted during W2. Required: fifo_write=0 the next cycle, all counters 0, and the FSM re-enters UNSYNC.
